// File: rtl/wb4_fifo_pkg.sv
// Shared helpers for the WB4 synchronous FIFO: address/count width derivation
// and parameter legality checks used at elaboration.
package wb4_fifo_pkg;

    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Pointer MSB: pointers wrap naturally over P_DEPTH entries.
    function automatic int addr_msb(input int depth);
        return ceil_log2(depth) - 1;
    endfunction

    // Count MSB: one extra bit so the count can represent 0..P_DEPTH.
    function automatic int cnt_msb(input int depth);
        return ceil_log2(depth);
    endfunction

    function automatic bit params_ok(input int depth, input int afull_lvl, input int aempty_lvl);
        bit pow2;
        pow2 = (depth >= 4) && ((depth & (depth - 1)) == 0);
        return pow2 && (afull_lvl >= 1) && (afull_lvl <= depth) &&
               (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
    endfunction

endpackage

// File: rtl/generic_sbram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port
// whose output holds between reads.
module generic_sbram #(
    parameter int P_DATA_W = 8,
    parameter int P_ADDR_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [P_ADDR_W-1:0] i_waddr,
    input  logic [P_DATA_W-1:0] i_wdata,
    input  logic                i_re,
    input  logic [P_ADDR_W-1:0] i_raddr,
    output logic [P_DATA_W-1:0] o_rdata
);

    logic [P_DATA_W-1:0] mem [2**P_ADDR_W];

    // NOTE: the array itself has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)  o_rdata <= '0;
        else if (i_re) o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/wb4_sync_fifo_flow.sv
// Wishbone B4 pipelined synchronous FIFO with registered flags and read data.
// Define WB4_FIFO_LEVEL_EN to expose the occupancy count on o_level.
module wb4_sync_fifo_flow
    import wb4_fifo_pkg::*;
#(
    parameter int P_DATA_MSB   = 7,
    parameter int P_DEPTH      = 16,
    parameter int P_AFULL_LVL  = 12,
    parameter int P_AEMPTY_LVL = 4,
    parameter int P_USE_BRAM   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wb4_in_scyc,
    input  logic                  i_wb4_in_sstb,
    input  logic [P_DATA_MSB:0]   i_wb4_in_sdata,
    output logic                  o_wb4_in_sack,
    output logic                  o_wb4_in_sstall,
    output logic                  o_wb4_in_stgd,
    input  logic                  i_wb4_out_scyc,
    input  logic                  i_wb4_out_sstb,
    output logic [P_DATA_MSB:0]   o_wb4_out_sdata,
    output logic                  o_wb4_out_sack,
    output logic                  o_wb4_out_sstall,
`ifdef WB4_FIFO_LEVEL_EN
    output logic                  o_wb4_out_stgd,
    output logic [cnt_msb(P_DEPTH):0] o_level
`else
    output logic                  o_wb4_out_stgd
`endif
);

    localparam int L_ADDR_MSB = addr_msb(P_DEPTH);
    localparam int L_CNT_MSB  = cnt_msb(P_DEPTH);
    localparam logic [L_CNT_MSB:0] L_FULL   = (L_CNT_MSB + 1)'(P_DEPTH);
    localparam logic [L_CNT_MSB:0] L_AFULL  = (L_CNT_MSB + 1)'(P_AFULL_LVL);
    localparam logic [L_CNT_MSB:0] L_AEMPTY = (L_CNT_MSB + 1)'(P_AEMPTY_LVL);

    if (!params_ok(P_DEPTH, P_AFULL_LVL, P_AEMPTY_LVL)) begin : g_param_err
        $error("wb4_sync_fifo_flow: P_DEPTH must be a power of 2 >= 4 and thresholds in range");
    end

    logic [L_ADDR_MSB:0] wr_ptr;
    logic [L_ADDR_MSB:0] rd_ptr;
    logic [L_CNT_MSB:0]  count;
    logic [L_CNT_MSB:0]  count_nxt;
    logic                in_stall_q;
    logic                out_stall_q;
    logic                afull_q;
    logic                aempty_q;
    logic                in_ack_q;
    logic                out_ack_q;
    logic                push;
    logic                pop;
    logic [P_DATA_MSB:0] rd_data;

    // Stalls are registered, so acceptance never depends combinationally on the strobe.
    assign push = i_wb4_in_scyc & i_wb4_in_sstb & ~in_stall_q;
    assign pop  = i_wb4_out_scyc & i_wb4_out_sstb & ~out_stall_q;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_stall_q  <= 1'b0;
            out_stall_q <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            in_ack_q    <= 1'b0;
            out_ack_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count       <= count_nxt;
            in_stall_q  <= (count_nxt == L_FULL);
            out_stall_q <= (count_nxt == '0);
            afull_q     <= (count_nxt >= L_AFULL);
            aempty_q    <= (count_nxt <= L_AEMPTY);
            in_ack_q    <= push;
            out_ack_q   <= pop;
        end
    end

    if (P_USE_BRAM != 0) begin : g_bram
        generic_sbram #(
            .P_DATA_W (P_DATA_MSB + 1),
            .P_ADDR_W (L_ADDR_MSB + 1)
        ) u_ram (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (push),
            .i_waddr (wr_ptr),
            .i_wdata (i_wb4_in_sdata),
            .i_re    (pop),
            .i_raddr (rd_ptr),
            .o_rdata (rd_data)
        );
    end else begin : g_lut
        logic [P_DATA_MSB:0] mem [P_DEPTH];

        always_ff @(posedge i_clk) begin
            if (push) mem[wr_ptr] <= i_wb4_in_sdata;
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) rd_data <= '0;
            else if (pop) rd_data <= mem[rd_ptr];
        end
    end

    // NOTE: acks are gated by the live cyc so a master that aborts in the ack cycle sees no ack.
    assign o_wb4_in_sack    = in_ack_q & i_wb4_in_scyc;
    assign o_wb4_out_sack   = out_ack_q & i_wb4_out_scyc;
    assign o_wb4_in_sstall  = in_stall_q;
    assign o_wb4_out_sstall = out_stall_q;
    assign o_wb4_in_stgd    = afull_q;
    assign o_wb4_out_stgd   = aempty_q;
    assign o_wb4_out_sdata  = rd_data;

`ifdef WB4_FIFO_LEVEL_EN
    assign o_level = count;
`endif

endmodule

// File: tb/tb_wb4_sync_fifo_flow.sv
// Directed bench for wb4_sync_fifo_flow (depth 8, afull 6, aempty 2) with a
// read-data scoreboard drained by a negedge monitor.
module tb_wb4_sync_fifo_flow;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       in_cyc = 1'b0;
    logic       in_stb = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ack;
    logic       in_stall;
    logic       in_tgd;
    logic       out_cyc = 1'b0;
    logic       out_stb = 1'b0;
    logic [7:0] out_data;
    logic       out_ack;
    logic       out_stall;
    logic       out_tgd;
`ifdef WB4_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_in_acks = 0;
    int         obs_in_acks = 0;
    logic [7:0] exp_rd [$];

    always #5 i_clk = ~i_clk;

    wb4_sync_fifo_flow #(
        .P_DATA_MSB   (7),
        .P_DEPTH      (8),
        .P_AFULL_LVL  (6),
        .P_AEMPTY_LVL (2),
        .P_USE_BRAM   (1)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_wb4_in_scyc    (in_cyc),
        .i_wb4_in_sstb    (in_stb),
        .i_wb4_in_sdata   (in_data),
        .o_wb4_in_sack    (in_ack),
        .o_wb4_in_sstall  (in_stall),
        .o_wb4_in_stgd    (in_tgd),
        .i_wb4_out_scyc   (out_cyc),
        .i_wb4_out_sstb   (out_stb),
        .o_wb4_out_sdata  (out_data),
        .o_wb4_out_sack   (out_ack),
        .o_wb4_out_sstall (out_stall),
`ifdef WB4_FIFO_LEVEL_EN
        .o_wb4_out_stgd   (out_tgd),
        .o_level          (level)
`else
        .o_wb4_out_stgd   (out_tgd)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_wr(input logic cyc, input logic stb, input logic [7:0] d);
        in_cyc  = cyc;
        in_stb  = stb;
        in_data = d;
    endtask

    task automatic set_rd(input logic cyc, input logic stb);
        out_cyc = cyc;
        out_stb = stb;
    endtask

    task automatic check_level(input string name, input logic [3:0] exp);
`ifdef WB4_FIFO_LEVEL_EN
        check(name, level, exp);
`endif
    endtask

    // Monitor: every visible read ack consumes one expected data word.
    always @(negedge i_clk) begin
        if (in_ack) obs_in_acks++;
        if (out_ack) begin
            if (exp_rd.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_ack_unexpected: got ack with data 0x%0h, required no ack", out_data);
            end else begin
                check("rd_data", out_data, exp_rd.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle
        repeat (3) step();
        i_rst_n = 1'b1;
        check("rst_flags", {in_stall, out_stall, in_tgd, out_tgd}, 4'b0101);
        check("rst_acks", {in_ack, out_ack}, 2'b00);
        check("rst_data", out_data, 8'h00);
        check_level("rst_level", 4'd0);
        set_wr(1'b1, 1'b0, 8'h00);
        set_rd(1'b1, 1'b0);
        step();

        // Fill 0x11..0x18 back to back
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 1'b1, 8'h11 + 8'(i));
            exp_in_acks++;
            step();
            check("fill_ack", in_ack, 1'b1);
            check("fill_afull", in_tgd, (i + 1 >= 6));
            check("fill_full", in_stall, (i + 1 == 8));
        end
        set_wr(1'b1, 1'b1, 8'h19);
        step();
        check("ninth_push_no_ack", in_ack, 1'b0);
        check("ninth_push_full", in_stall, 1'b1);
        check_level("full_level", 4'd8);

        // Full: simultaneous push/pop, push refused
        set_wr(1'b1, 1'b1, 8'h99);
        set_rd(1'b1, 1'b1);
        exp_rd.push_back(8'h11);
        step();
        check("full_pp_push_refused", in_ack, 1'b0);
        check("full_pp_pop_ack", out_ack, 1'b1);
        check("full_pp_flags", {in_stall, out_stall, in_tgd}, 3'b001);
        check_level("full_pp_level", 4'd7);
        set_wr(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            exp_rd.push_back(8'h12 + 8'(i));
            step();
            check("drain_aempty", out_tgd, (6 - i <= 2));
        end
        set_rd(1'b1, 1'b0);
        check("drain_empty", out_stall, 1'b1);

        // Empty: simultaneous push/pop, pop refused
        set_wr(1'b1, 1'b1, 8'hA5);
        set_rd(1'b1, 1'b1);
        exp_in_acks++;
        step();
        check("empty_pp_pop_refused", out_ack, 1'b0);
        check("empty_pp_push_ack", in_ack, 1'b1);
        check("empty_pp_not_empty", out_stall, 1'b0);
        set_wr(1'b1, 1'b0, 8'h00);
        exp_rd.push_back(8'hA5);
        step();
        check("empty_pp_pop_ack", out_ack, 1'b1);
        set_rd(1'b1, 1'b0);
        step();
        check("empty_pp_empty_again", out_stall, 1'b1);

        // Wrap: steady count of 3 with 20 push/pop pairs
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, 1'b1, 8'h30 + 8'(i));
            exp_in_acks++;
            step();
        end
        set_rd(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            set_wr(1'b1, 1'b1, 8'h40 + 8'(i));
            exp_in_acks++;
            exp_rd.push_back((i < 3) ? (8'h30 + 8'(i)) : (8'h40 + 8'(i - 3)));
            step();
            check("wrap_flags", {in_stall, out_stall, in_tgd, out_tgd}, 4'b0000);
            check_level("wrap_level", 4'd3);
        end
        set_wr(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(8'h51 + 8'(i));
            step();
        end
        set_rd(1'b1, 1'b0);
        step();
        check("wrap_empty", out_stall, 1'b1);

        // Abort: accepted pop with cyc dropped in the ack cycle
        for (int i = 0; i < 5; i++) begin
            set_wr(1'b1, 1'b1, 8'h60 + 8'(i));
            exp_in_acks++;
            step();
        end
        set_wr(1'b1, 1'b0, 8'h00);
        set_rd(1'b1, 1'b1);
        step();
        set_rd(1'b0, 1'b0);
        #1;
        check("abort_ack_suppressed", out_ack, 1'b0);
        check("abort_data_committed", out_data, 8'h60);
        check_level("abort_level", 4'd4);
        step();
        set_rd(1'b1, 1'b0);
        check("abort_flags", {in_stall, out_stall, in_tgd, out_tgd}, 4'b0000);

        // Strobe without cyc is ignored
        set_wr(1'b0, 1'b1, 8'hEE);
        step();
        set_wr(1'b1, 1'b0, 8'h00);
        #1;
        check("stb_no_cyc_ignored", in_ack, 1'b0);

        // Reset mid-operation with 5 entries
        set_wr(1'b1, 1'b1, 8'h65);
        exp_in_acks++;
        step();
        set_wr(1'b1, 1'b0, 8'h00);
        check_level("pre_rst_level", 4'd5);
        i_rst_n = 1'b0;
        step();
        check("midrst_flags", {in_stall, out_stall, in_tgd, out_tgd}, 4'b0101);
        check("midrst_acks", {in_ack, out_ack}, 2'b00);
        check("midrst_data", out_data, 8'h00);
        check_level("midrst_level", 4'd0);
        i_rst_n = 1'b1;
        step();
        set_rd(1'b1, 1'b1);
        step();
        check("post_rst_pop_refused", out_ack, 1'b0);
        set_wr(1'b1, 1'b1, 8'h77);
        exp_in_acks++;
        step();
        set_wr(1'b1, 1'b0, 8'h00);
        exp_rd.push_back(8'h77);
        step();
        check("post_rst_pop_ack", out_ack, 1'b1);
        set_rd(1'b1, 1'b0);
        step();
        step();

        check("rd_queue_drained", exp_rd.size(), 0);
        check("in_ack_count", obs_in_acks, exp_in_acks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb4_sync_fifo_flow.md
Name: wb4_sync_fifo_flow

Overview:
- Parametrised next-generation Wishbone B4 (pipelined) synchronous FIFO: one WB4 slave write port, one WB4 slave read port, one clock.
- Adds over the existing 1-to-1 FIFO: exact occupancy count, programmable almost-full/almost-empty flags, registered read data aligned with ack, and defined simultaneous push/pop and abort behaviour.
- Sits between WB4 producers/consumers in stream datapaths. Storage is inferred BRAM or LUT RAM.

Parameters:
- P_DATA_MSB, 7: data width minus 1.
- P_DEPTH, 16: number of entries; power of 2, minimum 4.
- P_AFULL_LVL, 12: o_wb4_in_stgd asserts when count >= this value; range 1..P_DEPTH.
- P_AEMPTY_LVL, 4: o_wb4_out_stgd asserts when count <= this value; range 0..P_DEPTH-1.
- P_USE_BRAM, 1: 1 = generic_sbram instance; 0 = LUT array with a registered read.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_wb4_in_scyc  in  1  write cycle.
- i_wb4_in_sstb  in  1  write strobe.
- i_wb4_in_sdata  in  P_DATA_MSB+1  write data.
- o_wb4_in_sack  out  1  write acknowledge.
- o_wb4_in_sstall  out  1  full.
- o_wb4_in_stgd  out  1  almost full.
- i_wb4_out_scyc  in  1  read cycle.
- i_wb4_out_sstb  in  1  read strobe.
- o_wb4_out_sdata  out  P_DATA_MSB+1  read data, valid with ack.
- o_wb4_out_sack  out  1  read acknowledge.
- o_wb4_out_sstall  out  1  empty.
- o_wb4_out_stgd  out  1  almost empty.
- o_level  out  $clog2(P_DEPTH)+1  occupancy; present only with WB4_FIFO_LEVEL_EN.

Behaviour:
- One clock domain. Reset is synchronous and active-low. All state updates on the rising edge of i_clk.
- Reset values: pointers 0, count 0, o_wb4_in_sack 0, o_wb4_out_sack 0, o_wb4_in_sstall 0, o_wb4_out_sstall 1, o_wb4_in_stgd 0 (P_AFULL_LVL >= 1), o_wb4_out_stgd 1, o_wb4_out_sdata 0, o_level 0.
- Pointers are $clog2(P_DEPTH) bits and wrap naturally from P_DEPTH-1 to 0. Count is $clog2(P_DEPTH)+1 bits, range 0..P_DEPTH.
- Push = in_scyc & in_sstb & ~in_sstall: write mem[wr_ptr], then wr_ptr+1.
- Pop = out_scyc & out_sstb & ~out_sstall: read mem[rd_ptr] into the output register, then rd_ptr+1.
- Stall outputs are registered and combinationally independent of strobe:
  - in_sstall = (count == P_DEPTH).
  - out_sstall = (count == 0).
- Count update: push only +1; pop only -1; push and pop together, no change.
- Full: a push is refused even when a pop happens in the same cycle. Stall releases the cycle after the pop.
- Empty: a pop is refused even when a push happens in the same cycle. Data becomes poppable the cycle after the push, so minimum write-to-read latency is 1 cycle.
- Acks:
  - in_sack = registered push. out_sack = registered pop. Latency 1 cycle in each case.
  - Back-to-back strobes give one ack per cycle, sustaining full throughput.
  - o_wb4_out_sdata is updated only on pop and holds otherwise.
- Abort: if scyc is low in the ack cycle, that ack is suppressed. The accepted push/pop is still committed and the pointers do not roll back.
- Strobe without cyc is ignored.
- Almost flags are registered from the next-state count, so they change in the same cycle as count.
- Reset mid-operation: all contents are discarded and outstanding acks are dropped in that cycle.

Optional Feature:
- Macro: WB4_FIFO_LEVEL_EN.
- Defined: the o_level port exists and equals the registered count.
- Undefined: the port is absent. Count logic is retained internally because the flags need it.

Decomposition:
- Package/include wb4_fifo_pkg holds:
  - a ceil-log2 helper;
  - localparam L_ADDR_MSB and L_CNT_MSB derivation;
  - elaboration checks (P_DEPTH a power of 2; threshold ranges).
- Sub-module: generic_sbram (already in the library) for the P_USE_BRAM=1 storage.
- Pointer/count/flag logic stays in a single always block. No further split.

Test Plan (P_DATA_MSB=7, P_DEPTH=8, P_AFULL_LVL=6, P_AEMPTY_LVL=2):
- Reset then idle: in_sstall=0, out_sstall=1, out_stgd=1, in_stgd=0, acks 0.
- Push 0x11..0x18 back-to-back: 8 in_acks on consecutive cycles; in_stgd rises after the 6th push; in_sstall=1 after the 8th; a 9th strobe gets no ack.
- Full FIFO, push and pop in the same cycle: pop accepted, push refused; out_sdata=0x11 with out_sack next cycle; count 7; in_sstall=0.
- Empty FIFO, push 0xA5 and pop in the same cycle: pop refused; next cycle pop gives out_sack with 0xA5 one cycle later.
- Wrap: 20 interleaved push/pop pairs at count 3: data order preserved across pointer wrap; count stays 3 throughout.
- Abort and reset: pop accepted, then out_scyc drops → no out_sack, count decremented. Then i_rst_n=0 with count 5 → count 0 and out_sstall=1 the next cycle; with WB4_FIFO_LEVEL_EN, o_level tracks count.
